// File: rtl/frame_write_ctrl_if.sv
// Write-burst channel between frame_write_ctrl (master) and one port of the DDR write arbiter.
interface frame_write_ctrl_if #(
    parameter int unsigned MEM_DATA_BITS = 32,
    parameter int unsigned ADDR_BITS     = 23,
    parameter int unsigned BUSRT_BITS    = 10
);
    logic                     wr_burst_req;
    logic [BUSRT_BITS-1:0]    wr_burst_len;
    logic [ADDR_BITS-1:0]     wr_burst_addr;
    logic                     wr_burst_data_req;
    logic [MEM_DATA_BITS-1:0] wr_burst_data;
    logic                     wr_burst_finish;

    modport master (
        output wr_burst_req,
        output wr_burst_len,
        output wr_burst_addr,
        output wr_burst_data,
        input  wr_burst_data_req,
        input  wr_burst_finish
    );

    modport slave (
        input  wr_burst_req,
        input  wr_burst_len,
        input  wr_burst_addr,
        input  wr_burst_data,
        output wr_burst_data_req,
        output wr_burst_finish
    );
endinterface

// File: rtl/frame_write_ctrl.sv
// Drains a show-ahead pixel FIFO into fixed-size DDR write bursts, rotating frames through
// four buffers and publishing the last completed buffer index to the read side.
module frame_write_ctrl #(
    parameter int unsigned MEM_DATA_BITS = 32,
    parameter int unsigned ADDR_BITS     = 23,
    parameter int unsigned BUSRT_BITS    = 10,
    parameter int unsigned BURST_SIZE    = 128,
    parameter int unsigned FIFO_CNT_BITS = 11,
    parameter int unsigned FRAME_SHIFT   = 19
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [ADDR_BITS-1:0]     base_addr,
    input  logic [ADDR_BITS-1:0]     frame_len,
    input  logic [FIFO_CNT_BITS-1:0] fifo_rdusedw,
    output logic                     fifo_rd_en,
    input  logic [MEM_DATA_BITS-1:0] fifo_rd_data,
    frame_write_ctrl_if.master       wr,
    output logic [1:0]               wr_frame_idx,
    output logic [1:0]               last_frame_idx,
    output logic                     frame_valid,
    output logic                     frame_done,
    output logic                     frame_err
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitData,
        StBurst,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_BITS-1:0]    base_q, base_d;
    logic [ADDR_BITS-1:0]    frame_len_q, frame_len_d;
    logic [ADDR_BITS-1:0]    offset_q, offset_d;
    logic [BUSRT_BITS-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BUSRT_BITS-1:0]   burst_len_q, burst_len_d;
    logic [ADDR_BITS-1:0]    burst_addr_q, burst_addr_d;
    logic                    burst_req_q, burst_req_d;
    logic [1:0]              wr_idx_q, wr_idx_d;
    logic [1:0]              last_idx_q, last_idx_d;
    logic                    valid_q, valid_d;
    logic                    start_pend_q, start_pend_d;

    logic [ADDR_BITS-1:0]    remaining;
    logic [ADDR_BITS-1:0]    blen;
    logic [ADDR_BITS-1:0]    frame_off;

    assign wr.wr_burst_req  = burst_req_q;
    assign wr.wr_burst_len  = burst_len_q;
    assign wr.wr_burst_addr = burst_addr_q;
    assign wr.wr_burst_data = fifo_rd_data;

    assign wr_frame_idx   = wr_idx_q;
    assign last_frame_idx = last_idx_q;
    assign frame_valid    = valid_q;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        frame_len_d  = frame_len_q;
        offset_d     = offset_q;
        beat_cnt_d   = beat_cnt_q;
        burst_len_d  = burst_len_q;
        burst_addr_d = burst_addr_q;
        burst_req_d  = burst_req_q;
        wr_idx_d     = wr_idx_q;
        last_idx_d   = last_idx_q;
        valid_d      = valid_q;
        start_pend_d = start_pend_q;
        frame_done   = 1'b0;
        frame_err    = 1'b0;

        remaining = frame_len_q - offset_q;
        blen      = (remaining > ADDR_BITS'(BURST_SIZE)) ? ADDR_BITS'(BURST_SIZE) : remaining;
        frame_off = ADDR_BITS'(wr_idx_q) << FRAME_SHIFT;

        // Extra data_req beats past the burst length must never touch the FIFO.
        fifo_rd_en = wr.wr_burst_data_req && (state_q == StBurst) && (beat_cnt_q < burst_len_q);
        if (fifo_rd_en) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        if (frame_start && (state_q != StIdle)) begin
            start_pend_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (frame_start && (frame_len != '0)) begin
                    base_d       = base_addr;
                    frame_len_d  = frame_len;
                    offset_d     = '0;
                    start_pend_d = 1'b0;
                    state_d      = StWaitData;
                end
            end
            StWaitData: begin
                if (start_pend_q) begin
                    // Restart into the same buffer; a start arriving now is the same restart.
                    base_d       = base_addr;
                    frame_len_d  = frame_len;
                    offset_d     = '0;
                    frame_err    = 1'b1;
                    start_pend_d = 1'b0;
                end else if (remaining == '0) begin
                    state_d = StDone;
                end else if (ADDR_BITS'(fifo_rdusedw) >= blen) begin
                    burst_len_d  = BUSRT_BITS'(blen);
                    burst_addr_d = base_q + frame_off + offset_q;
                    burst_req_d  = 1'b1;
                    beat_cnt_d   = '0;
                    state_d      = StBurst;
                end
            end
            StBurst: begin
                // The arbiter samples req only in its check state, so hold it until finish.
                if (wr.wr_burst_finish) begin
                    offset_d    = offset_q + ADDR_BITS'(burst_len_q);
                    burst_req_d = 1'b0;
                    state_d     = StWaitData;
                end
            end
            StDone: begin
                frame_done = 1'b1;
                last_idx_d = wr_idx_q;
                valid_d    = 1'b1;
                wr_idx_d   = wr_idx_q + 2'd1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            base_q       <= '0;
            frame_len_q  <= '0;
            offset_q     <= '0;
            beat_cnt_q   <= '0;
            burst_len_q  <= '0;
            burst_addr_q <= '0;
            burst_req_q  <= 1'b0;
            wr_idx_q     <= 2'd0;
            last_idx_q   <= 2'd0;
            valid_q      <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            frame_len_q  <= frame_len_d;
            offset_q     <= offset_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_len_q  <= burst_len_d;
            burst_addr_q <= burst_addr_d;
            burst_req_q  <= burst_req_d;
            wr_idx_q     <= wr_idx_d;
            last_idx_q   <= last_idx_d;
            valid_q      <= valid_d;
            start_pend_q <= start_pend_d;
        end
    end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Randomised scoreboard bench for frame_write_ctrl: a FIFO model, an arbiter model and an
// event monitor check the DUT against bursts and frame events predicted from frame geometry.
module tb_frame_write_ctrl;
    localparam int unsigned MEM_DATA_BITS = 32;
    localparam int unsigned ADDR_BITS     = 23;
    localparam int unsigned BUSRT_BITS    = 10;
    localparam int unsigned BURST_SIZE    = 128;
    localparam int unsigned FIFO_CNT_BITS = 11;
    localparam int unsigned FRAME_SHIFT   = 19;
    localparam int unsigned ADDR_MASK     = (1 << ADDR_BITS) - 1;
    localparam int unsigned TIMEOUT       = 5000;

    logic                     mem_clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     frame_start = 1'b0;
    logic [ADDR_BITS-1:0]     base_addr = '0;
    logic [ADDR_BITS-1:0]     frame_len = '0;
    logic [FIFO_CNT_BITS-1:0] fifo_rdusedw = '0;
    logic                     fifo_rd_en;
    logic [MEM_DATA_BITS-1:0] fifo_rd_data = '0;
    logic [1:0]               wr_frame_idx;
    logic [1:0]               last_frame_idx;
    logic                     frame_valid;
    logic                     frame_done;
    logic                     frame_err;

    frame_write_ctrl_if #(
        .MEM_DATA_BITS(MEM_DATA_BITS),
        .ADDR_BITS    (ADDR_BITS),
        .BUSRT_BITS   (BUSRT_BITS)
    ) wr_if ();

    frame_write_ctrl #(
        .MEM_DATA_BITS(MEM_DATA_BITS),
        .ADDR_BITS    (ADDR_BITS),
        .BUSRT_BITS   (BUSRT_BITS),
        .BURST_SIZE   (BURST_SIZE),
        .FIFO_CNT_BITS(FIFO_CNT_BITS),
        .FRAME_SHIFT  (FRAME_SHIFT)
    ) dut (
        .mem_clk       (mem_clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .base_addr     (base_addr),
        .frame_len     (frame_len),
        .fifo_rdusedw  (fifo_rdusedw),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .wr            (wr_if),
        .wr_frame_idx  (wr_frame_idx),
        .last_frame_idx(last_frame_idx),
        .frame_valid   (frame_valid),
        .frame_done    (frame_done),
        .frame_err     (frame_err)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        int unsigned addr;
        int unsigned len;
    } burst_t;

    typedef struct {
        bit          is_err;
        int unsigned idx;
    } evt_t;

    burst_t                   exp_burst[$];
    evt_t                     exp_evt[$];
    logic [MEM_DATA_BITS-1:0] fifo_q[$];

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned feed_total = 0, fed = 0, pops_req = 0, popped = 0;
    int unsigned bursts_seen = 0, bursts_done = 0, done_seen = 0, err_seen = 0, word_idx = 0;
    bit          arb_hold = 1'b0;
    int unsigned mdl_idx = 0, mdl_last = 0;
    bit          mdl_valid = 1'b0;

    function automatic logic [MEM_DATA_BITS-1:0] word_of(input int unsigned k);
        return {k[15:0] ^ 16'hC3A5, k[15:0]};
    endfunction

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned cnt(input int which);
        case (which)
            0:       return bursts_seen;
            1:       return bursts_done;
            2:       return done_seen;
            default: return fed;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int unsigned target);
        int unsigned t = 0;
        while (cnt(which) < target && t < TIMEOUT) begin
            @(negedge mem_clk);
            t++;
        end
        check(name, 64'(cnt(which) >= target), 64'd1);
    endtask

    // Show-ahead FIFO: producer trickles words in, pops follow observed fifo_rd_en beats.
    initial begin
        forever begin
            @(posedge mem_clk);
            if (popped < pops_req) begin
                popped++;
                check("fifo_not_underflowed", 64'(fifo_q.size() > 0), 64'd1);
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            if (fed < feed_total && $urandom_range(0, 3) != 0) begin
                fifo_q.push_back(word_of(fed));
                fed++;
            end
            fifo_rdusedw <= FIFO_CNT_BITS'(fifo_q.size());
            fifo_rd_data <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
        end
    end

    task automatic serve_burst();
        burst_t      eb;
        int unsigned len, extra, n_rd;
        bit          dropped;
        len = 32'(wr_if.wr_burst_len);
        bursts_seen++;
        check("burst_expected", 64'(exp_burst.size() != 0), 64'd1);
        if (exp_burst.size() != 0) begin
            eb = exp_burst.pop_front();
            check("burst_addr", 64'(wr_if.wr_burst_addr), 64'(eb.addr));
            check("burst_len", 64'(len), 64'(eb.len));
        end
        while (arb_hold) @(negedge mem_clk);
        extra   = (bursts_seen == 1) ? 2 : $urandom_range(0, 2);
        n_rd    = 0;
        dropped = 1'b0;
        for (int b = 0; b < int'(len + extra); b++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_if.wr_burst_data_req = 1'b0;
                @(negedge mem_clk);
            end
            wr_if.wr_burst_data_req = 1'b1;
            #1;
            if (!wr_if.wr_burst_req) dropped = 1'b1;
            if (fifo_rd_en) begin
                check("beat_data", 64'(wr_if.wr_burst_data), 64'(word_of(word_idx)));
                word_idx++;
                n_rd++;
                pops_req++;
            end
            @(negedge mem_clk);
        end
        wr_if.wr_burst_data_req = 1'b0;
        check("rd_en_per_burst", 64'(n_rd), 64'(len));
        repeat ($urandom_range(0, 2)) @(negedge mem_clk);
        check("req_held_to_finish", 64'({dropped, wr_if.wr_burst_req}), 64'd1);
        wr_if.wr_burst_finish = 1'b1;
        @(negedge mem_clk);
        wr_if.wr_burst_finish = 1'b0;
        check("req_low_after_finish", 64'(wr_if.wr_burst_req), 64'd0);
        bursts_done++;
    endtask

    // Arbiter channel model.
    initial begin
        wr_if.wr_burst_data_req = 1'b0;
        wr_if.wr_burst_finish   = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (rst_n && wr_if.wr_burst_req) serve_burst();
        end
    end

    // Frame event monitor.
    initial begin
        evt_t ev;
        forever begin
            @(negedge mem_clk);
            if (rst_n && (frame_done || frame_err)) begin
                check("event_expected", 64'(exp_evt.size() != 0), 64'd1);
                if (exp_evt.size() != 0) begin
                    ev = exp_evt.pop_front();
                    check("event_kind", 64'({frame_done, frame_err}), ev.is_err ? 64'd1 : 64'd2);
                    check("event_frame_idx", 64'(wr_frame_idx), 64'(ev.idx));
                end
                if (frame_done) done_seen++;
                if (frame_err) err_seen++;
            end
        end
    end

    task automatic plan_frame(input int unsigned base, input int unsigned len,
                              input int unsigned idx, input int unsigned upto);
        burst_t b;
        for (int unsigned off = 0; off < upto; off += BURST_SIZE) begin
            b.addr = (base + (idx << FRAME_SHIFT) + off) & ADDR_MASK;
            b.len  = (len - off > BURST_SIZE) ? BURST_SIZE : len - off;
            exp_burst.push_back(b);
        end
    endtask

    task automatic pulse_start(input int unsigned base, input int unsigned len);
        @(negedge mem_clk);
        base_addr   = ADDR_BITS'(base);
        frame_len   = ADDR_BITS'(len);
        frame_start = 1'b1;
        @(negedge mem_clk);
        frame_start = 1'b0;
    endtask

    task automatic check_status();
        check("wr_frame_idx", 64'(wr_frame_idx), 64'(mdl_idx));
        check("last_frame_idx", 64'(last_frame_idx), 64'(mdl_last));
        check("frame_valid", 64'(frame_valid), 64'(mdl_valid));
    endtask

    task automatic frame_completed();
        repeat (2) @(negedge mem_clk);
        mdl_last  = mdl_idx;
        mdl_idx   = (mdl_idx + 1) % 4;
        mdl_valid = 1'b1;
        check_status();
    endtask

    task automatic run_frame(input int unsigned base, input int unsigned len, input bit prefill);
        int unsigned target = done_seen + 1;
        plan_frame(base, len, mdl_idx, len);
        exp_evt.push_back('{1'b0, mdl_idx});
        feed_total += len;
        if (prefill) begin
            wait_for("prefill_timeout", 3, feed_total);
            repeat (2) @(negedge mem_clk);
        end
        pulse_start(base, len);
        wait_for("frame_done_timeout", 2, target);
        frame_completed();
    endtask

    task automatic do_reset();
        @(negedge mem_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge mem_clk);
        rst_n = 1'b1;
        mdl_idx   = 0;
        mdl_last  = 0;
        mdl_valid = 1'b0;
        @(negedge mem_clk);
        check("reset_req", 64'(wr_if.wr_burst_req), 64'd0);
        check("reset_rd_en", 64'(fifo_rd_en), 64'd0);
        check("reset_events", 64'({frame_done, frame_err}), 64'd0);
        check_status();
    endtask

    initial begin
        int unsigned t, d, e;
        int unsigned nb, nl;

        do_reset();

        // Two full bursts from a pre-filled FIFO.
        run_frame(0, 256, 1'b1);

        // 300-word frame: the 44-word tail must issue at 44 resident words, not 128.
        t = bursts_done;
        d = done_seen;
        plan_frame(0, 300, mdl_idx, 300);
        exp_evt.push_back('{1'b0, mdl_idx});
        feed_total += 276;
        pulse_start(0, 300);
        wait_for("two_bursts_timeout", 1, t + 2);
        repeat (30) @(negedge mem_clk);
        check("tail_waits_burst_count", 64'(bursts_seen), 64'(t + 2));
        check("tail_waits_req_low", 64'(wr_if.wr_burst_req), 64'd0);
        feed_total += 24;
        wait_for("frame300_done_timeout", 2, d + 1);
        frame_completed();

        // Early frame_start during the second burst: abort, restart into the same buffer.
        t = bursts_seen;
        d = done_seen;
        e = err_seen;
        plan_frame(32'h1234, 400, mdl_idx, 256);
        plan_frame(32'h2000, 200, mdl_idx, 200);
        exp_evt.push_back('{1'b1, mdl_idx});
        exp_evt.push_back('{1'b0, mdl_idx});
        feed_total += 256;
        pulse_start(32'h1234, 400);
        wait_for("second_burst_timeout", 0, t + 2);
        pulse_start(32'h2000, 200);
        feed_total += 200;
        wait_for("restart_done_timeout", 2, d + 1);
        check("abort_err_pulses", 64'(err_seen), 64'(e + 1));
        frame_completed();

        // Zero-length frame is ignored.
        t = bursts_seen;
        d = done_seen;
        pulse_start(32'h55, 0);
        repeat (20) @(negedge mem_clk);
        check("len0_no_req", 64'(wr_if.wr_burst_req), 64'd0);
        check("len0_no_burst", 64'(bursts_seen), 64'(t));
        check("len0_no_done", 64'(done_seen), 64'(d));
        check_status();

        // Five frames from a clean reset: buffer index walks 0..3 and wraps to 0.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_frame(32'h10, $urandom_range(1, 200), 1'b0);
        end

        // Random geometry, including bases that wrap the address space.
        for (int i = 0; i < 6; i++) begin
            nb = (i == 0) ? (ADDR_MASK - 50) : ($urandom() & ADDR_MASK);
            nl = $urandom_range(1, 700);
            run_frame(nb, nl, 1'b0);
        end

        // Reset asserted while a burst is granted but stalled.
        arb_hold = 1'b1;
        t = bursts_seen;
        plan_frame(32'h300, 128, mdl_idx, 128);
        feed_total += 128;
        pulse_start(32'h300, 128);
        wait_for("held_burst_timeout", 0, t + 1);
        repeat (3) @(negedge mem_clk);
        rst_n = 1'b0;
        #1;
        check("midburst_reset_req", 64'(wr_if.wr_burst_req), 64'd0);
        check("midburst_reset_len", 64'(wr_if.wr_burst_len), 64'd0);
        check("midburst_reset_addr", 64'(wr_if.wr_burst_addr), 64'd0);
        check("midburst_reset_idx", 64'({wr_frame_idx, last_frame_idx, frame_valid}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, %0d miscompares so far", miscompares);
        $fatal(1);
    end

endmodule

// File: doc/frame_write_ctrl.md
# frame_write_ctrl

Single write channel of the frame buffer. It drains a show-ahead pixel FIFO in the mem_clk domain and cuts each video frame into fixed-size DDR write bursts. It presents those bursts on one channel of the four-channel write arbiter (req/len/addr/data_req/data/finish) and rotates frames through four buffers. It reports the last completed buffer index so the read side can follow it.

## Interface
- MEM_DATA_BITS, 32, burst data width
- ADDR_BITS, 23, word address width
- BUSRT_BITS, 10, burst length width
- BURST_SIZE, 128, maximum words per burst (1..2^BUSRT_BITS-1)
- FIFO_CNT_BITS, 11, width of FIFO fill count
- FRAME_SHIFT, 19, log2 of per-buffer address stride in words

Ports:
- mem_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse, already synchronised to mem_clk (vsync)
- base_addr  in  ADDR_BITS  buffer-0 base word address, sampled on accepted frame_start
- frame_len  in  ADDR_BITS  words per frame, sampled on accepted frame_start
- fifo_rdusedw  in  FIFO_CNT_BITS  words available in pixel FIFO
- fifo_rd_en  out  1  FIFO read strobe (show-ahead: data valid before strobe)
- fifo_rd_data  in  MEM_DATA_BITS  FIFO head word
- wr_burst_req  out  1  burst request to arbiter channel
- wr_burst_len  out  BUSRT_BITS  burst length in words
- wr_burst_addr  out  ADDR_BITS  burst start word address
- wr_burst_data_req  in  1  arbiter pulls one word this cycle
- wr_burst_data  out  MEM_DATA_BITS  data to arbiter
- wr_burst_finish  in  1  one-cycle burst-complete pulse from arbiter
- wr_frame_idx  out  2  buffer currently being written
- last_frame_idx  out  2  most recently completed buffer
- frame_valid  out  1  at least one frame completed since reset
- frame_done  out  1  one-cycle pulse, frame fully written
- frame_err  out  1  one-cycle pulse, frame aborted by early frame_start

## Operation
- States:
  - IDLE: wait for frame_start. If frame_len==0, ignore it and stay. Otherwise latch base/len, offset<=0, go to WAIT_DATA.
  - WAIT_DATA: remaining=frame_len_q-offset; blen=min(BURST_SIZE, remaining).
    - If start_pend: abort (see below).
    - Else if remaining==0: go to DONE.
    - Else if fifo_rdusedw>=blen: register wr_burst_len=blen, wr_burst_addr=base_q+(wr_frame_idx<<FRAME_SHIFT)+offset (sum truncated to ADDR_BITS, wraps modulo 2^ADDR_BITS), set wr_burst_req=1, beat_cnt<=0, go to BURST.
  - BURST: wait for wr_burst_finish. On finish: offset+=wr_burst_len, wr_burst_req<=0, go to WAIT_DATA.
  - DONE: frame_done=1, last_frame_idx<=wr_frame_idx, frame_valid<=1, wr_frame_idx<=wr_frame_idx+1 (mod 4), go to IDLE.
- Data path:
  - wr_burst_data = fifo_rd_data, combinational.
  - fifo_rd_en = wr_burst_data_req & (state==BURST) & (beat_cnt<wr_burst_len).
  - beat_cnt increments on each fifo_rd_en. Beats beyond len never read the FIFO.
- wr_burst_req stays high from the BURST entry until the finish pulse. The arbiter samples it only in its check state, so it must not drop early.
- Early frame_start:
  - A frame_start outside IDLE sets start_pend.
  - A granted burst is never aborted. The abort happens on the next WAIT_DATA cycle: offset<=0, re-latch base/len, frame_err=1, start_pend<=0, same wr_frame_idx reused.
  - No frame_done, and last_frame_idx is unchanged.
- frame_start arriving in the same cycle that the abort consumes start_pend is absorbed: it is the same restart.
- FIFO underflow is impossible by construction: a burst is issued only when the full blen is resident.

## Timing
- Reset values: all outputs 0; wr_frame_idx=0, last_frame_idx=0, frame_valid=0, start_pend=0, state IDLE.
- frame_start (IDLE) -> WAIT_DATA next cycle.
- Sufficient FIFO level -> wr_burst_req/len/addr valid 1 cycle later, all registered together.
- Finish pulse in cycle N -> wr_burst_req low in N+1; next burst req at earliest N+2.
- Last finish -> WAIT_DATA (N+1) -> DONE (N+2, frame_done high for that cycle) -> IDLE (N+3).
- Reset asserted mid-burst: immediate return to reset values. The arbiter's own timeout recovers its side.

## Test plan
- Reset, then frame_start with frame_len=256, BURST_SIZE=128, FIFO pre-filled with 256 words -> two bursts, addr 0x000000 then 0x000080, len 128 each, 256 fifo_rd_en, frame_done once, last_frame_idx=0, wr_frame_idx=1, frame_valid=1.
- frame_len=300 -> bursts of 128, 128, 44 at offsets 0, 128, 256; the 44-beat burst waits until fifo_rdusedw>=44, not 128.
- Four consecutive frames, base_addr=0x10 -> burst addresses 0x10, 0x80010, 0x100010, 0x180010, then back to 0x10 (index wraps 3->0).
- frame_start pulsed during the second burst -> that burst completes (finish honoured), then frame_err pulses, the next burst uses offset 0 with the same frame index, and no frame_done occurs.
- Arbiter asserts wr_burst_data_req for 130 beats on a 128 burst -> exactly 128 fifo_rd_en, req held until finish, dropped the cycle after.
- frame_len=0 with frame_start -> state stays IDLE, no req, no frame_done.
